// File: rtl/cs_final_adder_if.sv
// cs_final_adder_if
//   Handshake bundle between the carry-save producer, the final adder and
//   the downstream consumer.
//   master : drives in_valid/r1/r2 and out_ready (producer + consumer side)
//   slave  : the adder; drives in_ready, out_valid, sum, cout
interface cs_final_adder_if #(
    parameter int WIDTH = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, r1, r2, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, r1, r2, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/cs_final_adder.sv
// cs_final_adder
//   Resolves a carry-save pair (r1, r2) into a binary sum, CHUNK bits per
//   clock, with the inter-chunk carry held in a register.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cs_final_adder_if.slave (in_valid/in_ready/r1/r2 in,
//              out_valid/out_ready/sum/cout out)
//   busy     : high while a pair is being added or its result is held
module cs_final_adder #(
    parameter int WIDTH = 10,
    parameter int CHUNK = 2
) (
    input  logic               clk,
    input  logic               rst,
    cs_final_adder_if.slave    bus,
    output logic               busy
);
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW     = NCHUNK * CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    // Valid bits in the final (possibly partial) chunk; the carry out of
    // bit WIDTH-1 lands at this position of the chunk result.
    localparam int LAST   = WIDTH - (NCHUNK - 1) * CHUNK;

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t                        state_q, state_d;
    // Operands and sum are stored chunk-addressed so chunk k is a plain
    // index; operands are zero-extended to a whole number of chunks.
    logic [NCHUNK-1:0][CHUNK-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                          carry_q, carry_d;
    logic                          cout_q, cout_d;
    logic [KW-1:0]                 k_q, k_d;
    logic [CHUNK:0]                tmp;
    logic [PW-1:0]                 sum_flat;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        k_d     = k_q;
        tmp     = {1'b0, a_q[k_q]} + {1'b0, b_q[k_q]} + (CHUNK+1)'(carry_q);
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = PW'(bus.r1);
                    b_d     = PW'(bus.r2);
                    carry_d = 1'b0;
                    k_d     = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                // Pad bits above WIDTH in the last chunk are internal only.
                sum_d[k_q] = tmp[CHUNK-1:0];
                if (k_q == KW'(NCHUNK - 1)) begin
                    cout_d  = tmp[LAST];
                    state_d = S_DONE;
                end else begin
                    carry_d = tmp[CHUNK];
                    k_d     = k_q + KW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            k_q     <= k_d;
        end
    end

    assign sum_flat      = sum_q;
    assign bus.sum       = sum_flat[WIDTH-1:0];
    assign bus.cout      = cout_q;
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign busy          = (state_q != S_IDLE);
endmodule
